// File: rtl/spi_chip_responder.sv
// ============================================================================
// Module      : spi_chip_responder
// Description : Chip-side SPI mode-0 responder; oversampled 64-bit frame decoder
//               driving a 32-bit register file (config) or a DAC code (waveform).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_chip_responder #(
    parameter int NREG   = 16,
    parameter int ADDR_W = 7,
    parameter int DAC_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sclk,
    input  logic                    cs_b,
    input  logic                    spi_sel,
    input  logic                    mosi,
    output logic                    miso,
    output logic [DAC_W-1:0]        dac_code,
    output logic                    dac_valid,
    output logic                    frame_done,
    output logic                    frame_err,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [31:0]             dbg_data
);

    localparam int AW = $clog2(NREG);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        WAIT_CS = 3'd2,
        EXEC    = 3'd3,
        ABORT   = 3'd4
    } state_t;

    state_t state, state_next;

    logic [1:0]  sclk_sync, cs_sync, mosi_sync, sel_sync;
    logic        sclk_prev, cs_prev;
    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic        frame_sel;
    logic [6:0]  cnt;
    logic [63:0] shreg;
    logic [31:0] rdata;
    logic [31:0] regs [NREG];

    logic [ADDR_W-1:0] rd_addr, ex_addr;
    logic              ex_write;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> AW) == '0;
    endfunction

    assign sclk_rise = ~sclk_prev &  sclk_sync[1];
    assign sclk_fall =  sclk_prev & ~sclk_sync[1];
    assign cs_rise   = ~cs_prev   &  cs_sync[1];
    assign cs_fall   =  cs_prev   & ~cs_sync[1];

    // After 9 bits the W flag sits at shreg[8] and the address at shreg[7:1].
    assign rd_addr  = shreg[7:1];
    assign ex_addr  = shreg[62:56];
    assign ex_write = shreg[63];
    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = SHIFT;
            SHIFT: begin
                if (cs_rise)                         state_next = ABORT;
                else if (sclk_rise && cnt == 7'd63)  state_next = WAIT_CS;
            end
            WAIT_CS: begin
                if (cs_rise)        state_next = EXEC;
                else if (sclk_rise) state_next = ABORT;
            end
            EXEC:    state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Synchronisers reset to "low" so a cs_b held low across reset release
    // never produces a falling edge; that frame is dropped until cs_b cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sel_sync  <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            cs_sync   <= {cs_sync[0], cs_b};
            mosi_sync <= {mosi_sync[0], mosi};
            sel_sync  <= {sel_sync[0], spi_sel};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_sel  <= 1'b0;
            cnt        <= '0;
            shreg      <= '0;
            rdata      <= '0;
            miso       <= 1'b0;
            dac_code   <= '0;
            dac_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            dac_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    miso  <= 1'b0;
                    rdata <= '0;
                    if (cs_fall) frame_sel <= sel_sync[1];
                end
                SHIFT: begin
                    if (!cs_rise) begin
                        if (sclk_rise) begin
                            shreg <= {shreg[62:0], mosi_sync[1]};
                            cnt   <= cnt + 7'd1;
                        end
                        if (sclk_fall) begin
                            miso <= (cnt[6:5] == 2'b01) ? rdata[~cnt[4:0]] : 1'b0;
                        end
                        if (cnt == 7'd9) begin
                            rdata <= (!frame_sel && !shreg[8] && in_range(rd_addr))
                                   ? regs[rd_addr[AW-1:0]] : 32'd0;
                        end
                    end
                end
                WAIT_CS: ;
                EXEC: begin
                    miso       <= 1'b0;
                    frame_done <= 1'b1;
                    if (frame_sel) begin
                        dac_code  <= shreg[DAC_W-1:0];
                        dac_valid <= 1'b1;
                    end else if (ex_write && in_range(ex_addr)) begin
                        regs[ex_addr[AW-1:0]] <= shreg[31:0];
                    end
                end
                ABORT: begin
                    miso      <= 1'b0;
                    frame_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_chip_responder.sv
// ============================================================================
// Module      : tb_spi_chip_responder
// Description : Directed self-checking bench for spi_chip_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_chip_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_b = 1'b1;
    logic        spi_sel = 1'b0;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] dac_code;
    logic        dac_valid, frame_done, frame_err;
    logic [3:0]  dbg_addr = 4'd0;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;
    int n_done = 0, n_err = 0, n_dv = 0;
    int d0, e0, v0;
    logic [63:0] cap;

    spi_chip_responder #(.NREG(16), .ADDR_W(7), .DAC_W(16)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_b(cs_b), .spi_sel(spi_sel),
        .mosi(mosi), .miso(miso), .dac_code(dac_code), .dac_valid(dac_valid),
        .frame_done(frame_done), .frame_err(frame_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
        if (dac_valid)  n_dv++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        d0 = n_done; e0 = n_err; v0 = n_dv;
    endtask

    task automatic clock_bit(input logic b);
        mosi = b;
        repeat (5) @(negedge clk);
        sclk = 1'b1;
        cap  = {cap[62:0], miso};
        repeat (5) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic sel, input logic [63:0] data, input int nbits);
        cap = '0;
        spi_sel = sel;
        repeat (4) @(negedge clk);
        cs_b = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) clock_bit((i < 64) ? data[63 - i] : 1'b0);
        repeat (5) @(negedge clk);
        cs_b = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic dbg(input logic [3:0] a, input string tag, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        check(tag, {32'd0, dbg_data}, {32'd0, exp});
    endtask

    function automatic logic [63:0] cfg(input logic w, input logic [6:0] a, input logic [31:0] d);
        return {w, a, 24'h00_0000, d};
    endfunction

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        check("reset_dac_code", {48'd0, dac_code}, 64'd0);
        check("reset_miso", {63'd0, miso}, 64'd0);
        check("reset_pulses", {61'd0, frame_done, frame_err, dac_valid}, 64'd0);
        dbg(4'd3, "reset_reg3", 32'd0);

        // Config write then dbg read-back
        mark();
        spi_frame(1'b0, cfg(1'b1, 7'd3, 32'hA5A5_1234), 64);
        dbg(4'd3, "write3_reg", 32'hA5A5_1234);
        check("write3_done", n_done - d0, 1);
        check("write3_err", n_err - e0, 0);

        // Config read over miso: first 32 bits zero, last 32 = register
        mark();
        spi_frame(1'b0, cfg(1'b0, 7'd3, 32'hFFFF_FFFF), 64);
        check("read3_low", {32'd0, cap[31:0]}, 64'hA5A5_1234);
        check("read3_high", {32'd0, cap[63:32]}, 64'd0);
        check("read3_done", n_done - d0, 1);

        // Waveform frame
        mark();
        spi_frame(1'b1, 64'hFFFF_0000_1234_8001, 64);
        check("wave_dac", {48'd0, dac_code}, 64'h8001);
        check("wave_valid", n_dv - v0, 1);
        check("wave_done", n_done - d0, 1);
        dbg(4'd3, "wave_reg3", 32'hA5A5_1234);

        // Early cs_b rise after 40 bits
        mark();
        spi_frame(1'b0, cfg(1'b1, 7'd5, 32'h1111_2222), 40);
        check("abort40_err", n_err - e0, 1);
        check("abort40_done", n_done - d0, 0);
        dbg(4'd5, "abort40_reg5", 32'd0);
        mark();
        spi_frame(1'b0, cfg(1'b1, 7'd5, 32'h0BAD_F00D), 64);
        dbg(4'd5, "after_abort_reg5", 32'h0BAD_F00D);
        check("after_abort_done", n_done - d0, 1);
        spi_frame(1'b0, cfg(1'b0, 7'd5, 32'd0), 64);
        check("read5_low", {32'd0, cap[31:0]}, 64'h0BAD_F00D);

        // 65 sclk pulses
        mark();
        spi_frame(1'b0, cfg(1'b1, 7'd6, 32'h1234_5678), 65);
        check("over65_err", n_err - e0, 1);
        check("over65_done", n_done - d0, 0);
        dbg(4'd6, "over65_reg6", 32'd0);

        // Out-of-range address
        mark();
        spi_frame(1'b0, cfg(1'b1, 7'd20, 32'hFFFF_FFFF), 64);
        check("oor_done", n_done - d0, 1);
        check("oor_err", n_err - e0, 0);
        dbg(4'd4, "oor_reg4", 32'd0);
        dbg(4'd3, "oor_reg3", 32'hA5A5_1234);
        spi_frame(1'b0, cfg(1'b0, 7'd20, 32'd0), 64);
        check("oor_read", cap, 64'd0);

        // Reset at bit 30 of a write
        mark();
        cap = '0;
        spi_sel = 1'b0;
        repeat (4) @(negedge clk);
        cs_b = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 30; i++) clock_bit(cfg(1'b1, 7'd7, 32'h7777_7777) >> (63 - i));
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_dac", {48'd0, dac_code}, 64'd0);
        check("rst_mid_miso", {63'd0, miso}, 64'd0);
        dbg(4'd3, "rst_mid_reg3", 32'd0);
        dbg(4'd5, "rst_mid_reg5", 32'd0);
        rst = 1'b0;
        mark();
        for (int i = 30; i < 64; i++) clock_bit(cfg(1'b1, 7'd7, 32'h7777_7777) >> (63 - i));
        repeat (5) @(negedge clk);
        cs_b = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_ignored_done", n_done - d0, 0);
        check("rst_ignored_err", n_err - e0, 0);
        dbg(4'd7, "rst_ignored_reg7", 32'd0);
        mark();
        spi_frame(1'b0, cfg(1'b1, 7'd7, 32'hCAFE_BABE), 64);
        dbg(4'd7, "post_rst_reg7", 32'hCAFE_BABE);
        check("post_rst_done", n_done - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_chip_responder.md
Name: spi_chip_responder

Overview:
- Chip-side SPI responder: the far end of the host SPI master link (CS_B, SPI_SEL, MOSI, MISO).
- Oversamples the serial lines on the system clock, decodes 64-bit frames, and executes them against an internal 32-bit register file.
- Config frames read or write registers; waveform frames load a DAC code.
- Used as a bench/FPGA loopback model of the chip and as a standalone checker of the master's framing.

Parameters:
- NREG, 16, number of 32-bit config registers (power of 2, ≤128).
- ADDR_W, 7, frame address field width (fixed frame layout).
- DAC_W, 16, width of the DAC code taken from waveform frames.

Ports:
- clk  in  1  system clock (512 kHz nominal)
- rst  in  1  synchronous active-high reset
- sclk  in  1  SPI clock from master, asynchronous
- cs_b  in  1  chip select, active low, asynchronous
- spi_sel  in  1  frame type: 0 = config, 1 = waveform; sampled at cs_b fall
- mosi  in  1  serial data in, MSB first
- miso  out  1  serial data out
- dac_code  out  DAC_W  last accepted waveform code
- dac_valid  out  1  one-cycle pulse when dac_code updates
- frame_done  out  1  one-cycle pulse after each complete 64-bit frame
- frame_err  out  1  one-cycle pulse on an aborted frame (cs_b high before bit 64, or more than 64 bits)
- dbg_addr  in  $clog2(NREG)  register file debug read address
- dbg_data  out  32  combinational read of reg[dbg_addr]

Behaviour:
- Synchronisation:
  - sclk, cs_b and mosi each pass through 2-flop synchronisers; edge detect on the synchronised sclk and cs_b.
  - A physical edge is acted on 3 clk later.
  - Requirement on the master: sclk high and low phases ≥4 clk each.
- Frame format, MSB first, 64 bits:
  - Config (spi_sel=0): bit63 = W (1 write, 0 read); bits62:56 = addr; bits55:32 reserved (ignored); bits31:0 = wdata.
  - Waveform (spi_sel=1): bits DAC_W-1:0 = code; other bits ignored.
- Mode 0 timing: mosi sampled on sclk rising edge; miso updated on sclk falling edge.
- FSM states:
  - IDLE: miso=0, bit counter=0. On cs_b fall, latch spi_sel → SHIFT.
  - SHIFT: on each rising sclk, shift mosi into the 64-bit shreg and increment the 7-bit counter.
    - When the counter reaches 9 (W+addr complete) on a config read, load rdata = reg[addr] (0 if addr≥NREG).
    - miso drives rdata[31] on the falling edge after bit 32 is received, then successive bits on each falling edge; 0 before that and for writes.
    - When the counter reaches 64 → WAIT_CS.
    - cs_b rise with counter<64 → ABORT.
  - WAIT_CS: a further rising sclk → ABORT. On cs_b rise → EXEC.
  - EXEC (1 clk), then IDLE, with frame_done=1:
    - Config write with addr<NREG: reg[addr] ← wdata.
    - addr≥NREG: write dropped, frame_done still pulses.
    - Waveform: dac_code ← shreg[DAC_W-1:0], dac_valid=1.
  - ABORT (1 clk): frame_err=1; no register or DAC update; then IDLE once cs_b is high.
- cs_b fall while not in IDLE (cannot occur without a rise first) is ignored. cs_b rise and sclk edge recognised in the same cycle: cs_b takes priority.
- Reset, in any state including mid-frame:
  - All registers = 0, dac_code = 0, miso = 0, dac_valid = frame_done = frame_err = 0, FSM → IDLE, counter = 0.
  - If rst releases while cs_b is low, the current frame is ignored until cs_b rises.
- Read-after-write within back-to-back frames returns the new value (EXEC completes before the next cs_b fall is recognised).

Test Plan:
- Config write addr 3, data 0xA5A5_1234, then dbg_addr=3 → dbg_data=0xA5A5_1234, exactly one frame_done, frame_err=0.
- Config read of addr 3 in the next frame → the last 32 miso bits, captured on rising sclk, equal 0xA5A5_1234; the first 32 bits are 0.
- Waveform frame with low 16 bits 0x8001 → dac_code=0x8001, one dac_valid pulse 1 clk after internal cs_b rise; registers unchanged.
- cs_b raised after 40 bits of a write to addr 5 → frame_err pulse, reg[5] stays 0, no frame_done; the next full frame succeeds.
- 65 sclk pulses in one frame → frame_err, no update; write to addr 20 (≥NREG) → frame_done, dbg reads unchanged, read returns 0.
- rst asserted at bit 30 of a write → all outputs 0; frame ignored until cs_b rises; subsequent frame decoded correctly.
